// File: rtl/mhp_frame_tx.sv
// MHP frame transmitter: Ethernet header, 8-byte MHP header, payload and zero pad toward the MAC.
// Define MHP_TX_FCS_EN to append an IEEE 802.3 CRC-32 FCS after the pad.
module mhp_frame_tx #(
    parameter logic [47:0] SRC_MAC     = 48'h26731bc9110c,
    parameter logic [15:0] ETHERTYPE   = 16'h88B5,
    parameter int          MIN_PAYLOAD = 38,
    parameter int          MAX_PAYLOAD = 1492
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hdr_valid,
    output logic        hdr_ready,
    input  logic [47:0] hdr_dst_mac,
    input  logic [63:0] hdr_mhp,
    input  logic [10:0] hdr_len,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic        s_last,
    output logic [7:0]  m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        m_last,
    output logic        busy,
    output logic        err_len
);

    localparam logic [10:0] MIN_L = 11'(MIN_PAYLOAD);
    localparam logic [10:0] MAX_L = 11'(MAX_PAYLOAD);

    typedef enum logic [3:0] {
        IDLE, ETH, MHP, PAYLOAD, ZFILL, PAD, TAIL, DRAIN
`ifdef MHP_TX_FCS_EN
        , FCS
`endif
    } state_t;

    state_t      state_q, state_d;
    logic [10:0] cnt_q, cnt_d;
    logic [10:0] pay_q, pay_d;
    logic        drain_q, drain_d;
    logic [7:0]  m_data_q, m_data_d;
    logic        m_valid_q, m_valid_d;
    logic        m_last_q, m_last_d;
    logic        err_q, err_d;

    logic [47:0]       dst_q;
    logic [63:0]       mhp_q;
    logic [10:0]       len_q;
    logic [10:0]       len_in;
    logic [0:13][7:0]  eth_b;
    logic [0:7][7:0]   mhp_b;
    logic [10:0]       pay_next;
    logic              load, accept, emit, last, done;
    logic [7:0]        byte_d;
    logic              unused_ok;

    assign load      = !m_valid_q || m_ready;
    assign accept    = hdr_valid && (state_q == IDLE);
    assign len_in    = (hdr_len > MAX_L) ? MAX_L : hdr_len;
    assign eth_b     = {dst_q, SRC_MAC, ETHERTYPE};
    assign mhp_b     = mhp_q;
    assign pay_next  = pay_q + 11'd1;
    assign unused_ok = ^hdr_mhp[15:5];

`ifdef MHP_TX_FCS_EN
    logic [31:0]      crc_q;
    logic [3:0][7:0]  fcs_b;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'd0, d};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    assign fcs_b = ~crc_q;
`endif

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        pay_d     = pay_q;
        drain_d   = drain_q;
        m_data_d  = m_data_q;
        m_valid_d = m_valid_q && !m_ready;
        m_last_d  = m_last_q && !m_ready;
        err_d     = 1'b0;
        s_ready   = 1'b0;
        emit      = 1'b0;
        last      = 1'b0;
        done      = 1'b0;
        byte_d    = 8'h00;

        case (state_q)
            IDLE: if (hdr_valid) begin
                // The output stage is always empty here, so the first address byte loads on accept.
                state_d = ETH;
                cnt_d   = 11'd1;
                pay_d   = 11'd0;
                drain_d = 1'b0;
                err_d   = hdr_len > MAX_L;
                emit    = 1'b1;
                byte_d  = hdr_dst_mac[47:40];
            end
            ETH: if (load) begin
                emit   = 1'b1;
                byte_d = eth_b[cnt_q[3:0]];
                cnt_d  = cnt_q + 11'd1;
                if (cnt_q == 11'd13) begin
                    state_d = MHP;
                    cnt_d   = 11'd0;
                end
            end
            MHP: if (load) begin
                emit   = 1'b1;
                byte_d = mhp_b[cnt_q[2:0]];
                cnt_d  = cnt_q + 11'd1;
                if (cnt_q == 11'd7) begin
                    state_d = (len_q != 11'd0) ? PAYLOAD : PAD;
                    cnt_d   = 11'd0;
                end
            end
            PAYLOAD: begin
                s_ready = load;
                if (load && s_valid) begin
                    emit   = 1'b1;
                    byte_d = s_data;
                    pay_d  = pay_next;
                    if (pay_next == len_q) begin
                        err_d   = !s_last;
                        drain_d = !s_last;
                        state_d = PAD;
                        done    = pay_next >= MIN_L;
                    end else if (s_last) begin
                        err_d   = 1'b1;
                        state_d = ZFILL;
                    end
                end
            end
            ZFILL: if (load) begin
                emit  = 1'b1;
                pay_d = pay_next;
                if (pay_next == len_q) begin
                    state_d = PAD;
                    done    = pay_next >= MIN_L;
                end
            end
            PAD: if (load) begin
                emit  = 1'b1;
                pay_d = pay_next;
                done  = pay_next >= MIN_L;
            end
`ifdef MHP_TX_FCS_EN
            FCS: if (load) begin
                emit   = 1'b1;
                byte_d = fcs_b[cnt_q[1:0]];
                cnt_d  = cnt_q + 11'd1;
                if (cnt_q == 11'd3) begin
                    state_d = TAIL;
                    last    = 1'b1;
                end
            end
`endif
            TAIL: if (m_ready) state_d = drain_q ? DRAIN : IDLE;
            DRAIN: begin
                s_ready = 1'b1;
                if (s_valid && s_last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (done) begin
`ifdef MHP_TX_FCS_EN
            state_d = FCS;
            cnt_d   = 11'd0;
`else
            state_d = TAIL;
            last    = 1'b1;
`endif
        end

        if (emit) begin
            m_data_d  = byte_d;
            m_valid_d = 1'b1;
            m_last_d  = last;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= 11'd0;
            pay_q     <= 11'd0;
            drain_q   <= 1'b0;
            m_data_q  <= 8'h00;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pay_q     <= pay_d;
            drain_q   <= drain_d;
            m_data_q  <= m_data_d;
            m_valid_q <= m_valid_d;
            m_last_q  <= m_last_d;
            err_q     <= err_d;
        end
    end

    // NOTE: descriptor and CRC registers carry no reset; each frame writes them before they are read.
    always_ff @(posedge clk) begin
        if (accept) begin
            dst_q <= hdr_dst_mac;
            mhp_q <= {hdr_mhp[63:16], len_in, hdr_mhp[4:0]};
            len_q <= len_in;
        end
`ifdef MHP_TX_FCS_EN
        if (emit && state_q != FCS)
            crc_q <= crc_byte(accept ? 32'hFFFFFFFF : crc_q, byte_d);
`endif
    end

    assign hdr_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE) && (state_q != DRAIN);
    assign m_data    = m_data_q;
    assign m_valid   = m_valid_q;
    assign m_last    = m_last_q;
    assign err_len   = err_q;

endmodule

// File: tb/tb_mhp_frame_tx.sv
// Directed self-checking bench for mhp_frame_tx; follows MHP_TX_FCS_EN when defined.
module tb_mhp_frame_tx;

`ifdef MHP_TX_FCS_EN
    localparam int FB = 4;
`else
    localparam int FB = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        hdr_valid;
    logic        hdr_ready;
    logic [47:0] hdr_dst_mac;
    logic [63:0] hdr_mhp;
    logic [10:0] hdr_len;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_ready;
    logic        s_last;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_ready;
    logic        m_last;
    logic        busy;
    logic        err_len;

    always #5 clk = ~clk;

    mhp_frame_tx dut (
        .clk(clk), .rst_n(rst_n),
        .hdr_valid(hdr_valid), .hdr_ready(hdr_ready), .hdr_dst_mac(hdr_dst_mac),
        .hdr_mhp(hdr_mhp), .hdr_len(hdr_len),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
        .busy(busy), .err_len(err_len)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] pay [2048];
    logic [7:0] rx[$];
    logic [7:0] exp_q[$];
    int errs, stall_viol, drain_viol, consumed;

    localparam logic [47:0] DST = 48'h0200_1122_3344;
    localparam logic [63:0] MHP = 64'hA55A_1234_0201_07FF;  // low 16 bits 0x07FF

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_crc(input logic [7:0] q[$], input int n);
        logic [31:0] c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {24'd0, q[i]};
            for (int b = 0; b < 8; b++)
                c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    // Reference frame: header fields, first nsend payload bytes, zeros up to the padded length.
    task automatic build_expected(input logic [63:0] mhp, input int len, input int nsend);
        int         len_eff;
        int         region;
        logic [63:0] m;
        logic [31:0] c;
        len_eff = (len > 1492) ? 1492 : len;
        region  = (len_eff > 38) ? len_eff : 38;
        m = {mhp[63:16], 11'(len_eff), mhp[4:0]};
        exp_q.delete();
        for (int i = 0; i < 6; i++) exp_q.push_back(8'(DST >> (40 - 8*i)));
        for (int i = 0; i < 6; i++) exp_q.push_back(8'(48'h26731bc9110c >> (40 - 8*i)));
        exp_q.push_back(8'h88);
        exp_q.push_back(8'hB5);
        for (int i = 0; i < 8; i++) exp_q.push_back(8'(m >> (56 - 8*i)));
        for (int i = 0; i < region; i++)
            exp_q.push_back((i < len_eff && i < nsend) ? pay[i] : 8'h00);
        if (FB == 4) begin
            c = ref_crc(exp_q, exp_q.size());
            for (int i = 0; i < 4; i++) exp_q.push_back(8'(c >> (8*i)));
        end
    endtask

    function automatic int mismatches();
        int n = 0;
        for (int i = 0; i < exp_q.size(); i++)
            if (i >= rx.size() || rx[i] !== exp_q[i]) n++;
        return n;
    endfunction

    // Drives one descriptor and nsend payload bytes (s_last on the final one), collects the frame.
    task automatic run_frame(input logic [63:0] mhp, input int len, input int nsend, input bit toggle);
        int         si = 0;
        int         cyc = 0;
        bit         acc = 0, got_last = 0, prev_stall = 0, timed_out = 0;
        logic [7:0] prev_data = 8'h00;
        rx.delete();
        errs = 0; stall_viol = 0; drain_viol = 0;
        hdr_dst_mac = DST; hdr_mhp = mhp; hdr_len = 11'(len); hdr_valid = 1'b1;
        m_ready = 1'b1;
        s_valid = (nsend > 0); s_data = pay[0]; s_last = (nsend == 1);
        forever begin
            @(negedge clk);
            if (hdr_valid && hdr_ready) acc = 1;
            if (s_valid && s_ready) si++;
            if (prev_stall && (!m_valid || m_data !== prev_data)) stall_viol++;
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            if (m_valid && m_ready) begin
                rx.push_back(m_data);
                if (m_last) got_last = 1;
            end
            if (err_len) errs++;
            if (got_last && si < nsend && hdr_ready) drain_viol++;
            if (acc && got_last && si >= nsend && hdr_ready) break;
            if (++cyc > 5000) begin
                timed_out = 1;
                break;
            end
            @(posedge clk);
            #1;
            if (acc) hdr_valid = 1'b0;
            s_valid = (si < nsend);
            s_data  = pay[si];
            s_last  = (si == nsend - 1);
            m_ready = toggle ? !m_ready : 1'b1;
        end
        consumed  = si;
        hdr_valid = 1'b0; s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b1;
        check("frame_done", timed_out, 0);
    endtask

    initial begin
        int si;
        rst_n = 1'b0; hdr_valid = 1'b0; hdr_dst_mac = '0; hdr_mhp = '0; hdr_len = '0;
        s_data = '0; s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_hdr_ready", hdr_ready, 1);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_last", m_last, 0);
        check("rst_m_data", m_data, 0);
        check("rst_busy", busy, 0);
        check("rst_err_len", err_len, 0);
        check("rst_s_ready", s_ready, 0);

        // Short frame, padded to the minimum.
        pay[0] = 8'hDE; pay[1] = 8'hAD; pay[2] = 8'hBE; pay[3] = 8'hEF;
        run_frame(MHP, 4, 4, 0);
        build_expected(MHP, 4, 4);
        check("t1_len", rx.size(), 60 + FB);
        check("t1_dst0", rx[0], 8'h02);
        check("t1_src0", rx[6], 8'h26);
        check("t1_src5", rx[11], 8'h0C);
        check("t1_etype", {rx[12], rx[13]}, 16'h88B5);
        check("t1_mhp0", rx[14], 8'hA5);
        check("t1_psize", {rx[20], rx[21]}, 16'h009F);
        check("t1_pay", {rx[22], rx[23], rx[24], rx[25]}, 32'hDEADBEEF);
        check("t1_pad_last", rx[59], 8'h00);
        check("t1_err", errs, 0);
        check("t1_model", mismatches(), 0);

        // Ramp with downstream stalls every other cycle.
        for (int i = 0; i < 100; i++) pay[i] = 8'(i + 1);
        run_frame(MHP, 100, 100, 1);
        build_expected(MHP, 100, 100);
        check("t2_len", rx.size(), 122 + FB);
        check("t2_first", rx[22], 8'h01);
        check("t2_last_pay", rx[121], 8'h64);
        check("t2_stall_stable", stall_viol, 0);
        check("t2_err", errs, 0);
        check("t2_model", mismatches(), 0);

        // Early s_last: zero fill to the declared length, then pad.
        for (int i = 0; i < 10; i++) pay[i] = 8'(8'h30 + i);
        run_frame(MHP, 10, 6, 0);
        build_expected(MHP, 10, 6);
        check("t3_err", errs, 1);
        check("t3_len", rx.size(), 60 + FB);
        check("t3_b6", rx[27], 8'h35);
        check("t3_zfill", {rx[28], rx[29], rx[30], rx[31]}, 32'h0);
        check("t3_model", mismatches(), 0);

        // Sender overruns the declared length: extra bytes are drained.
        for (int i = 0; i < 8; i++) pay[i] = 8'(8'hA0 + i);
        run_frame(MHP, 5, 8, 0);
        build_expected(MHP, 5, 8);
        check("t4_err", errs, 1);
        check("t4_len", rx.size(), 60 + FB);
        check("t4_last_pay", rx[26], 8'hA4);
        check("t4_after", rx[27], 8'h00);
        check("t4_drained", consumed, 8);
        check("t4_hdr_ready_hold", drain_viol, 0);
        check("t4_model", mismatches(), 0);

        // Oversized request is clamped.
        for (int i = 0; i < 1492; i++) pay[i] = 8'(i * 7);
        run_frame(MHP, 2000, 1492, 0);
        build_expected(MHP, 2000, 1492);
        check("t5_err", errs, 1);
        check("t5_len", rx.size(), 1514 + FB);
        check("t5_psize", {rx[20], rx[21]}, 16'hBA9F);
        check("t5_model", mismatches(), 0);

        // Empty payload: pure pad frame (plus FCS when enabled).
        run_frame(MHP, 0, 0, 0);
        build_expected(MHP, 0, 0);
        check("t6_len", rx.size(), 60 + FB);
        check("t6_pad", rx[22], 8'h00);
        check("t6_model", mismatches(), 0);
`ifdef MHP_TX_FCS_EN
        check("t6_fcs", {rx[63], rx[62], rx[61], rx[60]}, ref_crc(rx, 60));
`endif

        // Reset in the middle of the payload.
        for (int i = 0; i < 50; i++) pay[i] = 8'(i);
        hdr_dst_mac = DST; hdr_mhp = MHP; hdr_len = 11'd50; hdr_valid = 1'b1;
        s_valid = 1'b1; s_data = 8'h55; s_last = 1'b0; m_ready = 1'b1;
        si = 0;
        for (int c = 0; c < 300 && si < 5; c++) begin
            @(negedge clk);
            if (s_valid && s_ready) si++;
            @(posedge clk);
            #1;
            if (!hdr_ready) hdr_valid = 1'b0;
        end
        check("t7_reached_payload", si >= 5, 1);
        check("t7_busy", busy, 1);
        check("t7_m_valid_pre", m_valid, 1);
        rst_n = 1'b0; hdr_valid = 1'b0; s_valid = 1'b0;
        @(posedge clk);
        #1;
        check("t7_m_valid_rst", m_valid, 0);
        check("t7_m_last_rst", m_last, 0);
        check("t7_busy_rst", busy, 0);
        check("t7_s_ready_rst", s_ready, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("t7_hdr_ready", hdr_ready, 1);
        check("t7_m_valid_after", m_valid, 0);

        pay[0] = 8'hDE; pay[1] = 8'hAD; pay[2] = 8'hBE; pay[3] = 8'hEF;
        run_frame(MHP, 4, 4, 0);
        build_expected(MHP, 4, 4);
        check("t7_recover_len", rx.size(), 60 + FB);
        check("t7_recover_model", mismatches(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
